if_inst_buffer: RTL and testbench

IF_INST_BUFFER -- requirements
Module: if_inst_buffer

---
 rtl/if_inst_buffer.sv | 58 +++++
 tb/tb_if_inst_buffer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/if_inst_buffer.sv
// if_inst_buffer: tracks outstanding fetches, drops responses owned by flushed instructions,
// and buffers one fetch word while IF is stalled by ID.
module if_inst_buffer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid_i,
  input  logic        id_allowin_i,
  input  logic        excep_flush_i,
  input  logic        inst_ram_req_i,
  input  logic        inst_sram_addr_ok_i,
  input  logic        inst_sram_data_ok_i,
  input  logic [63:0] inst_sram_rdata_i,
  output logic        inst_sram_data_ok_o,
  output logic        inst_rdata_buffer_ok_o,
  output logic [63:0] inst_rdata_buffer_rdata_o,
  output logic        req_allow_o,
  output logic        proto_err_o
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_nxt;
  logic [1:0] out_cnt, out_cnt_nxt, drop_cnt, drop_cnt_nxt;
  logic accept, resp, hand, ovf, udf, capture, err_set;
  assign accept = inst_ram_req_i & inst_sram_addr_ok_i;
  assign resp = inst_sram_data_ok_i;
  assign hand = if_valid_i & id_allowin_i;
  assign ovf = accept & ~resp & (out_cnt == 2'd2);
  assign udf = resp & ~accept & (out_cnt == 2'd0);
  assign inst_sram_data_ok_o = resp & (drop_cnt == 2'd0) & ~excep_flush_i;
  assign req_allow_o = out_cnt < 2'd2;
  assign inst_rdata_buffer_ok_o = state == FULL;
  assign capture = (state == EMPTY) & inst_sram_data_ok_o & ~hand;
  assign err_set = ovf | udf | ((state == FULL) & inst_sram_data_ok_o);
  // out_cnt_nxt is already out_cnt + accept - response clamped to [0,2], which is what a flush drops
  always_comb begin
    out_cnt_nxt = (accept & ~resp & ~ovf) ? out_cnt + 2'd1 :
                  (resp & ~accept & ~udf) ? out_cnt - 2'd1 : out_cnt;
    drop_cnt_nxt = excep_flush_i ? out_cnt_nxt :
                   (resp & (drop_cnt != 2'd0)) ? drop_cnt - 2'd1 : drop_cnt;
    state_nxt = excep_flush_i ? EMPTY :
                (state == FULL) ? (hand ? EMPTY : FULL) :
                capture ? FULL : EMPTY;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt <= 2'd0;
      drop_cnt <= 2'd0;
      state <= EMPTY;
      inst_rdata_buffer_rdata_o <= 64'h0;
      proto_err_o <= 1'b0;
    end else begin
      out_cnt <= out_cnt_nxt;
      drop_cnt <= drop_cnt_nxt;
      state <= state_nxt;
      if (capture) inst_rdata_buffer_rdata_o <= inst_sram_rdata_i;
      if (err_set) proto_err_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_if_inst_buffer.sv
// tb_if_inst_buffer: directed and random stimulus checked against a queue-of-fetches model.
module tb_if_inst_buffer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic if_valid_i = 1'b0, id_allowin_i = 1'b0, excep_flush_i = 1'b0;
  logic inst_ram_req_i = 1'b0, inst_sram_addr_ok_i = 1'b0, inst_sram_data_ok_i = 1'b0;
  logic [63:0] inst_sram_rdata_i = 64'h0;
  logic inst_sram_data_ok_o, inst_rdata_buffer_ok_o, req_allow_o, proto_err_o;
  logic [63:0] inst_rdata_buffer_rdata_o;
  int total = 0, bad = 0;
  bit q[$];
  bit m_full, m_err;
  logic [63:0] m_word;
  always #5 clk = ~clk;
  if_inst_buffer dut (
    .clk(clk), .rst_n(rst_n), .if_valid_i(if_valid_i), .id_allowin_i(id_allowin_i),
    .excep_flush_i(excep_flush_i), .inst_ram_req_i(inst_ram_req_i),
    .inst_sram_addr_ok_i(inst_sram_addr_ok_i), .inst_sram_data_ok_i(inst_sram_data_ok_i),
    .inst_sram_rdata_i(inst_sram_rdata_i), .inst_sram_data_ok_o(inst_sram_data_ok_o),
    .inst_rdata_buffer_ok_o(inst_rdata_buffer_ok_o),
    .inst_rdata_buffer_rdata_o(inst_rdata_buffer_rdata_o),
    .req_allow_o(req_allow_o), .proto_err_o(proto_err_o)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    q.delete();
    m_full = 0;
    m_err = 0;
    m_word = 64'h0;
  endtask
  // Each queue entry is one outstanding fetch; 1 marks a fetch owned by a flushed instruction.
  task automatic step(input bit req, input bit aok, input bit dok, input bit ifv, input bit alw,
                      input bit fl, input logic [63:0] rd);
    bit fwd, acc;
    @(negedge clk);
    inst_ram_req_i = req;
    inst_sram_addr_ok_i = aok;
    inst_sram_data_ok_i = dok;
    if_valid_i = ifv;
    id_allowin_i = alw;
    excep_flush_i = fl;
    inst_sram_rdata_i = rd;
    #1;
    acc = req & aok;
    fwd = dok && !(q.size() > 0 && q[0]) && !fl;
    chk("data_ok_o", inst_sram_data_ok_o, fwd);
    chk("req_allow", req_allow_o, q.size() < 2);
    chk("buffer_ok", inst_rdata_buffer_ok_o, m_full);
    chk("buffer_rdata", inst_rdata_buffer_rdata_o, m_word);
    chk("proto_err", proto_err_o, m_err);
    if (!(acc && dok && q.size() == 0)) begin
      if (dok) begin
        if (q.size() > 0) void'(q.pop_front());
        else m_err = 1;
      end
      if (acc) begin
        if (q.size() == 2) m_err = 1;
        else q.push_back(1'b0);
      end
    end
    if (fl) foreach (q[i]) q[i] = 1'b1;
    if (fl) m_full = 0;
    else if (m_full) begin
      if (fwd) m_err = 1;
      if (ifv && alw) m_full = 0;
    end else if (fwd && !(ifv && alw)) begin
      m_full = 1;
      m_word = rd;
    end
    @(posedge clk);
  endtask
  task automatic async_reset();
    @(negedge clk);
    {inst_ram_req_i, inst_sram_addr_ok_i, inst_sram_data_ok_i, if_valid_i, id_allowin_i, excep_flush_i} = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_buffer_ok", inst_rdata_buffer_ok_o, 1'b0);
    chk("rst_req_allow", req_allow_o, 1'b1);
    chk("rst_data_ok", inst_sram_data_ok_o, 1'b0);
    chk("rst_err", proto_err_o, 1'b0);
    chk("rst_rdata", inst_rdata_buffer_rdata_o, 64'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    model_reset();
    #1;
    chk("init_req_allow", req_allow_o, 1'b1);
    chk("init_data_ok", inst_sram_data_ok_o, 1'b0);
    chk("init_buffer_ok", inst_rdata_buffer_ok_o, 1'b0);
    chk("init_rdata", inst_rdata_buffer_rdata_o, 64'h0);
    chk("init_err", proto_err_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    // stall capture then hand-off
    step(1, 1, 0, 1, 0, 0, 64'h0);
    step(0, 0, 0, 1, 0, 0, 64'h0);
    step(0, 0, 1, 1, 0, 0, 64'h1111_2222_3333_4444);
    #1;
    chk("stall_bok", inst_rdata_buffer_ok_o, 1'b1);
    chk("stall_rdata", inst_rdata_buffer_rdata_o, 64'h1111_2222_3333_4444);
    step(0, 0, 0, 1, 0, 0, 64'h0);
    step(0, 0, 0, 1, 1, 0, 64'h0);
    #1;
    chk("handoff_bok", inst_rdata_buffer_ok_o, 1'b0);
    chk("hold_rdata", inst_rdata_buffer_rdata_o, 64'h1111_2222_3333_4444);
    // direct pass
    step(1, 1, 0, 1, 0, 0, 64'h0);
    step(0, 0, 1, 1, 1, 0, 64'hdead_beef_0000_0001);
    #1;
    chk("pass_bok", inst_rdata_buffer_ok_o, 1'b0);
    chk("pass_allow", req_allow_o, 1'b1);
    // flush drops two in-flight responses
    step(1, 1, 0, 0, 0, 0, 64'h0);
    step(1, 1, 0, 0, 0, 0, 64'h0);
    #1;
    chk("two_out_allow", req_allow_o, 1'b0);
    step(0, 0, 0, 0, 0, 1, 64'h0);
    step(0, 0, 1, 1, 0, 0, 64'h5);
    step(0, 0, 1, 1, 0, 0, 64'h6);
    step(1, 1, 0, 1, 0, 0, 64'h0);
    step(0, 0, 1, 1, 0, 0, 64'h7777);
    #1;
    chk("after_drop_bok", inst_rdata_buffer_ok_o, 1'b1);
    chk("after_drop_rdata", inst_rdata_buffer_rdata_o, 64'h7777);
    step(0, 0, 0, 1, 1, 0, 64'h0);
    // flush with same-cycle response
    step(1, 1, 0, 1, 0, 0, 64'h0);
    step(0, 0, 1, 1, 0, 1, 64'h9);
    #1;
    chk("flush_resp_bok", inst_rdata_buffer_ok_o, 1'b0);
    chk("flush_resp_allow", req_allow_o, 1'b1);
    step(1, 1, 0, 0, 0, 0, 64'h0);
    step(0, 0, 1, 1, 0, 0, 64'hab);
    step(0, 0, 0, 1, 1, 0, 64'h0);
    // protocol-legal random traffic
    for (int n = 0; n < 400; n++) begin
      bit rq, dk;
      rq = (q.size() < 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      dk = (q.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      step(rq, 1'($urandom_range(0, 1)), dk, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0, {$urandom, $urandom});
    end
    for (int n = 0; n < 4 && q.size() > 0; n++) step(0, 0, 1, 1, 1, 0, 64'h0);
    step(0, 0, 0, 1, 1, 0, 64'h0);
    // limit and sticky error
    step(1, 1, 0, 0, 0, 0, 64'h0);
    step(1, 1, 0, 0, 0, 0, 64'h0);
    #1;
    chk("limit_allow", req_allow_o, 1'b0);
    step(1, 1, 0, 0, 0, 0, 64'h0);
    #1;
    chk("ovf_err", proto_err_o, 1'b1);
    chk("ovf_allow", req_allow_o, 1'b0);
    step(0, 0, 0, 0, 0, 0, 64'h0);
    step(0, 0, 0, 0, 0, 0, 64'h0);
    async_reset();
    // reset mid-operation while FULL with two outstanding
    step(1, 1, 0, 1, 0, 0, 64'h0);
    step(1, 1, 0, 1, 0, 0, 64'h0);
    step(0, 0, 1, 1, 0, 0, 64'hcafe);
    step(1, 1, 0, 1, 0, 0, 64'h0);
    #1;
    chk("pre_rst_bok", inst_rdata_buffer_ok_o, 1'b1);
    chk("pre_rst_allow", req_allow_o, 1'b0);
    async_reset();
    step(0, 0, 1, 0, 0, 0, 64'h1);
    step(0, 0, 0, 0, 0, 0, 64'h0);
    #1;
    chk("stale_resp_err", proto_err_o, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
